// File: rtl/stopwatch_counter.sv
// stopwatch_counter
//   Stopwatch timing core. Resynchronises the 100 Hz clk_div square wave and
//   the debounced buttons into the clk100MHz domain, runs an IDLE/RUN/STOP
//   state machine and counts hundredths of a second as four BCD digits
//   (00.00 .. 99.99), wrapping back to 00.00.
//
// Parameters
//   SYNC_STAGES     flops per input synchroniser (2 or 3)
//
// Ports
//   clk100MHz       system clock
//   rst             asynchronous, active-high reset
//   clk_div         100 Hz tick source, asynchronous
//   btn_start_stop  debounced level, rising edge toggles run/stop
//   btn_clear       debounced level, rising edge clears the count when not running
//   btn_lap         debounced level, rising edge freezes/unfreezes the display
//   sec_tens, sec_ones, csec_tens, csec_ones   BCD display digits
//   running         high while in RUN
//   wrap            one-cycle pulse on rollover 99.99 -> 00.00
//   lap_active      high while the displayed value is frozen
//
// Build option
//   STOPWATCH_LAP_EN  when defined, builds the lap register and display freeze;
//                     otherwise btn_lap has no effect and lap_active is 0.

module stopwatch_counter #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk100MHz,
   input  logic       rst,
   input  logic       clk_div,
   input  logic       btn_start_stop,
   input  logic       btn_clear,
   input  logic       btn_lap,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic [3:0] csec_tens,
   output logic [3:0] csec_ones,
   output logic       running,
   output logic       wrap,
   output logic       lap_active
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   // Bit positions of each input inside the synchroniser vectors
   localparam int unsigned IN_TICK = 0;
   localparam int unsigned IN_SS   = 1;
   localparam int unsigned IN_CLR  = 2;
   localparam int unsigned IN_LAP  = 3;

   // ------------------------------------------------------------------
   // Input synchronisers + history flop, all four inputs side by side.
   // sync_q[0] is the first stage, sync_q[SYNC_STAGES-1] the last.
   // ------------------------------------------------------------------
   logic [3:0]                    in_raw;
   logic [SYNC_STAGES-1:0][3:0]   sync_q, sync_d;
   logic [3:0]                    hist_q, hist_d;
   logic [3:0]                    edge_w;

   always_comb begin
      in_raw = {btn_lap, btn_clear, btn_start_stop, clk_div};
      sync_d = {sync_q[SYNC_STAGES-2:0], in_raw};
      hist_d = sync_q[SYNC_STAGES-1];
      edge_w = sync_q[SYNC_STAGES-1] & ~hist_q;
   end

   logic tick_e, ss_e, clr_e;
   assign tick_e = edge_w[IN_TICK];
   assign ss_e   = edge_w[IN_SS];
   assign clr_e  = edge_w[IN_CLR];

   // ------------------------------------------------------------------
   // State machine and BCD counter
   // ------------------------------------------------------------------
   state_t          state_q, state_d;
   logic [3:0][3:0] cnt_q, cnt_d;     // [0] = hundredths ... [3] = seconds tens
   logic            running_q, running_d;
   logic            wrap_q, wrap_d;
   logic            inc;
   logic            clr_cnt;
   logic            carry;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            // clear beats start_stop outside RUN; IDLE just stays IDLE
            if (!clr_e && ss_e) state_d = RUN;
         end
         RUN: begin
            // clear is ignored while running
            if (ss_e) state_d = STOP;
         end
         STOP: begin
            if (clr_e)     state_d = IDLE;
            else if (ss_e) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase

      // Count only on the registered state: a tick coinciding with a stop
      // edge is counted, one coinciding with a start edge is not.
      inc     = tick_e && (state_q == RUN);
      clr_cnt = clr_e && (state_q != RUN);

      cnt_d = cnt_q;
      carry = inc;
      for (int unsigned i = 0; i < 4; i++) begin
         if (carry) begin
            if (cnt_q[i] >= 4'd9) begin
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 4'd1;
               carry    = 1'b0;
            end
         end
      end
      // carry surviving past the top digit means 99.99 -> 00.00
      wrap_d = carry;
      if (clr_cnt) cnt_d = '0;

      running_d = (state_d == RUN);
   end

   always_ff @(posedge clk100MHz or posedge rst) begin
      if (rst) begin
         sync_q    <= '0;
         hist_q    <= '0;
         state_q   <= IDLE;
         cnt_q     <= '0;
         running_q <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         hist_q    <= hist_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         running_q <= running_d;
         wrap_q    <= wrap_d;
      end
   end

   assign running = running_q;
   assign wrap    = wrap_q;

   // ------------------------------------------------------------------
   // Display path
   // ------------------------------------------------------------------
   logic [3:0][3:0] disp;

`ifdef STOPWATCH_LAP_EN
   logic [3:0][3:0] lap_cnt_q, lap_cnt_d;
   logic            lap_active_q, lap_active_d;
   logic            lap_e;

   assign lap_e = edge_w[IN_LAP];

   always_comb begin
      lap_cnt_d    = lap_cnt_q;
      lap_active_d = lap_active_q;
      // Leaving RUN (including start_stop beating a lap edge) always
      // releases the freeze so the stopped total is visible.
      if (state_d != RUN) begin
         lap_active_d = 1'b0;
      end else if ((state_q == RUN) && lap_e) begin
         if (!lap_active_q) begin
            lap_cnt_d    = cnt_q;
            lap_active_d = 1'b1;
         end else begin
            lap_active_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk100MHz or posedge rst) begin
      if (rst) begin
         lap_cnt_q    <= '0;
         lap_active_q <= 1'b0;
      end else begin
         lap_cnt_q    <= lap_cnt_d;
         lap_active_q <= lap_active_d;
      end
   end

   always_comb begin
      disp = lap_active_q ? lap_cnt_q : cnt_q;
   end
   assign lap_active = lap_active_q;
`else
   // Lap input is still synchronised but nothing consumes its edge
   logic unused_lap;
   assign unused_lap = edge_w[IN_LAP];

   always_comb begin
      disp = cnt_q;
   end
   assign lap_active = 1'b0;
`endif

   assign csec_ones = disp[0];
   assign csec_tens = disp[1];
   assign sec_ones  = disp[2];
   assign sec_tens  = disp[3];

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter
//   Scoreboard bench for stopwatch_counter. Stimulus pushes expected output
//   snapshots into a queue; a monitor pops one entry per falling clock edge
//   and compares it against the DUT outputs.

module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_div = 1'b0;
  logic       bss = 1'b0;
  logic       bclr = 1'b0;
  logic       blap = 1'b0;
  logic [3:0] sec_tens, sec_ones, csec_tens, csec_ones;
  logic       running, wrap, lap_active;

  stopwatch_counter #(.SYNC_STAGES(2)) dut (
    .clk100MHz      (clk),
    .rst            (rst),
    .clk_div        (clk_div),
    .btn_start_stop (bss),
    .btn_clear      (bclr),
    .btn_lap        (blap),
    .sec_tens       (sec_tens),
    .sec_ones       (sec_ones),
    .csec_tens      (csec_tens),
    .csec_ones      (csec_ones),
    .running        (running),
    .wrap           (wrap),
    .lap_active     (lap_active)
  );

  always #5 clk = ~clk;

  // {digits[15:0], running, lap_active, wrap}
  logic [18:0] exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string nm, input int v, input logic run,
                          input logic lap, input logic wr);
    exp_q.push_back({to_bcd(v), run, lap, wr});
    name_q.push_back(nm);
  endtask

  // expectation for the very next falling edge
  task automatic check(input string nm, input int v, input logic run,
                       input logic lap, input logic wr);
    push_exp(nm, v, run, lap, wr);
    cyc(1);
  endtask

  task automatic ticks(input int n, input int hi, input int lo);
    for (int unsigned k = 0; k < n; k++) begin
      clk_div = 1'b1;
      cyc(hi);
      clk_div = 1'b0;
      cyc(lo);
    end
  endtask

  task automatic press(input logic ss, input logic clr, input logic lp, input logic tk);
    bss = ss; bclr = clr; blap = lp; clk_div = tk;
    cyc(4);
    bss = 1'b0; bclr = 1'b0; blap = 1'b0; clk_div = 1'b0;
    cyc(4);
  endtask

  // Monitor: one scoreboard entry per falling edge
  initial begin
    logic [18:0] act, e;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {sec_tens, sec_ones, csec_tens, csec_ones, running, lap_active, wrap};
        n_cmp++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL %s: got %h%h.%h%h run=%b lap=%b wrap=%b, want %h%h.%h%h run=%b lap=%b wrap=%b",
                   nm, act[18:15], act[14:11], act[10:7], act[6:3], act[2], act[1], act[0],
                   e[18:15], e[14:11], e[10:7], e[6:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    // Reset state
    cyc(3);
    check("reset", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(2);

    // Run to 12.34, then reset mid-count
    press(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(1234, 3, 3);
    check("count_1234", 1234, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    check("rst_mid", 0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    rst = 1'b0;
    cyc(2);

    // Start latency: running rises on the third edge after the input
    bss = 1'b1;
    push_exp("lat_0", 0, 1'b0, 1'b0, 1'b0);
    push_exp("lat_1", 0, 1'b0, 1'b0, 1'b0);
    push_exp("lat_2", 0, 1'b0, 1'b0, 1'b0);
    push_exp("lat_3", 0, 1'b1, 1'b0, 1'b0);
    cyc(4);
    bss = 1'b0;
    cyc(4);

    // Counting with a 20-clock tick period, then stop
    ticks(105, 10, 10);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    check("stop_0105", 105, 1'b0, 1'b0, 1'b0);
    ticks(10, 10, 10);
    check("hold_0105", 105, 1'b0, 1'b0, 1'b0);

    // Clear in STOP
    press(1'b0, 1'b1, 1'b0, 1'b0);
    check("clear_stop", 0, 1'b0, 1'b0, 1'b0);

    // Clear ignored in RUN
    press(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(50, 3, 3);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    check("clr_in_run", 50, 1'b1, 1'b0, 1'b0);
    ticks(5, 3, 3);
    check("run_after_clr", 55, 1'b1, 1'b0, 1'b0);

    // Simultaneous start_stop + clear in RUN, then in STOP
    press(1'b1, 1'b1, 1'b0, 1'b0);
    check("ss_clr_run", 55, 1'b0, 1'b0, 1'b0);
    ticks(3, 3, 3);
    check("stopped_hold", 55, 1'b0, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0, 1'b0);
    check("ss_clr_stop", 0, 1'b0, 1'b0, 1'b0);

    // Tick coinciding with stop and with restart
    press(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(7, 3, 3);
    check("count_0007", 7, 1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b1);
    check("tick_on_stop", 8, 1'b0, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b1);
    check("tick_on_start", 8, 1'b1, 1'b0, 1'b0);
    ticks(1, 3, 3);
    check("count_0009", 9, 1'b1, 1'b0, 1'b0);

    // Rollover
    press(1'b1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    check("clear_pre_roll", 0, 1'b0, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(9998, 3, 3);
    check("count_9998", 9998, 1'b1, 1'b0, 1'b0);
    ticks(1, 3, 3);
    check("count_9999", 9999, 1'b1, 1'b0, 1'b0);
    clk_div = 1'b1;
    push_exp("roll_c0", 9999, 1'b1, 1'b0, 1'b0);
    push_exp("roll_c1", 9999, 1'b1, 1'b0, 1'b0);
    push_exp("roll_c2", 9999, 1'b1, 1'b0, 1'b0);
    push_exp("roll_wrap", 0, 1'b1, 1'b0, 1'b1);
    push_exp("roll_after", 0, 1'b1, 1'b0, 1'b0);
    cyc(3);
    clk_div = 1'b0;
    cyc(3);
    ticks(1, 3, 3);
    check("count_0001", 1, 1'b1, 1'b0, 1'b0);

`ifdef STOPWATCH_LAP_EN
    press(1'b1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(20, 3, 3);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    check("lap_freeze", 20, 1'b1, 1'b1, 1'b0);
    ticks(30, 3, 3);
    check("lap_held", 20, 1'b1, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    check("lap_release", 50, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(3, 3, 3);
    check("lap_again", 50, 1'b1, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    check("lap_stop", 53, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    check("lap_in_stop", 53, 1'b0, 1'b0, 1'b0);
`else
    press(1'b0, 1'b0, 1'b1, 1'b0);
    check("lap_ignored", 1, 1'b1, 1'b0, 1'b0);
    ticks(4, 3, 3);
    check("lap_live", 5, 1'b1, 1'b0, 1'b0);
`endif

    cyc(3);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard: %0d expectations never compared, want 0", exp_q.size());
    end
    if (n_cmp < 12) begin
      n_bad++;
      $display("FAIL scoreboard: only %0d comparisons made, want at least 12", n_cmp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    if (n_bad != 0) $display("TEST FAILED");
    else            $display("TEST PASSED");
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Stopwatch timing core fed by the 100 Hz `clk_div` square wave of the clock divider. It resynchronises that wave into the `clk100MHz` domain and turns each rising edge into a one-cycle tick. It runs a start/stop/clear state machine and counts hundredths of a second as four BCD digits, 00.00 to 99.99. The digit outputs drive the display multiplexer downstream.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages in each input synchroniser; legal values are 2 and 3.
- `clk100MHz` in, 1 bit: system clock, 100 MHz.
- `rst` in, 1 bit: asynchronous, active-high reset.
- `clk_div` in, 1 bit: 100 Hz square wave from the clock divider; asynchronous to this block's logic.
- `btn_start_stop` in, 1 bit: debounced level; each rising edge toggles run/stop.
- `btn_clear` in, 1 bit: debounced level; a rising edge clears the count.
- `btn_lap` in, 1 bit: debounced level; used only when `STOPWATCH_LAP_EN` is defined.
- `sec_tens` out, 4 bits: BCD digit, seconds tens.
- `sec_ones` out, 4 bits: BCD digit, seconds ones.
- `csec_tens` out, 4 bits: BCD digit, tenths of a second.
- `csec_ones` out, 4 bits: BCD digit, hundredths of a second.
- `running` out, 1 bit: high while the state is RUN.
- `wrap` out, 1 bit: one-cycle pulse when the count rolls over from 99.99 to 00.00.
- `lap_active` out, 1 bit: high while the displayed value is frozen.

## Operation
- **Input synchronisers.** `clk_div`, `btn_start_stop`, `btn_clear` and `btn_lap` each pass through a `SYNC_STAGES` flip-flop chain, followed by one history flop. An edge is `sync_out & ~history`, which is high for exactly one cycle.
- **Tick.** The tick is the rising edge of the synchronised `clk_div`. Falling edges are ignored.
- **State machine.** States are IDLE, RUN and STOP. Reset state is IDLE.
  - IDLE, start_stop edge: go to RUN.
  - RUN, start_stop edge: go to STOP.
  - STOP, start_stop edge: go to RUN.
  - IDLE or STOP, clear edge: go to IDLE and zero all four digits.
  - RUN, clear edge: ignored.
- **Simultaneous button edges:**
  - In RUN, start_stop wins and the block goes to STOP; the clear edge is discarded.
  - In STOP or IDLE, clear wins and the block goes to IDLE; the start_stop edge is discarded.
- **Counting.**
  - The count increments on a tick only if the registered state is RUN in that cycle.
  - A tick in the same cycle as a RUN→STOP edge is counted.
  - A tick in the same cycle as an IDLE/STOP→RUN edge is not counted.
- **BCD increment:**
  - `csec_ones` counts 0–9; each 9→0 carries into `csec_tens`.
  - `csec_tens` counts 0–9; each 9→0 carries into `sec_ones`, and so on up to `sec_tens`.
  - Each digit stays within 0–9 at all times.
  - At 99.99 the next tick gives 00.00, asserts `wrap` for one cycle, and counting continues.
- **Display path.** The digit outputs show either the live count register or the lap register, selected by `lap_active`.
- **Reset mid-operation.** Asserting `rst` at any time forces:
  - the state to IDLE;
  - all digits to 0;
  - `running`, `wrap` and `lap_active` to 0;
  - all synchroniser and history flops to 0.

## Timing
- **Reset values of every output:** all digits 0, `running` 0, `wrap` 0, `lap_active` 0.
- **Tick latency (`SYNC_STAGES`=2):** `clk_div` sampled high for the first time at clock edge N gives:
  - edge detect high in the cycle after edge N+1;
  - count register and digit outputs updated at edge N+2.
  - Each extra sync stage adds one cycle.
- **Button latency:** identical to the tick latency.
  - The state register updates at edge N+2.
  - `running` is registered, so it changes at the same edge as the state.
- **`wrap` timing:** asserted in the cycle the outputs show 00.00 after rollover; deasserted on the following edge.
- **Minimum input high and low time:** `SYNC_STAGES`+1 clock cycles. Shorter pulses may be missed.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- **Macro:** `STOPWATCH_LAP_EN`.
- **Defined:**
  - A lap edge in RUN with `lap_active`=0 copies the live count into the lap register and sets `lap_active` to 1.
  - The displayed digits freeze while the live count continues.
  - A second lap edge in RUN clears `lap_active` and returns the display to the live count on the next cycle.
  - Lap edges in STOP or IDLE are ignored.
  - A RUN→STOP transition or any transition to IDLE clears `lap_active`, so the stopped total is displayed.
  - If lap and start_stop edges arrive in the same cycle in RUN, start_stop wins and `lap_active` becomes 0.
- **Not defined:**
  - `btn_lap` is ignored and the lap register is not built.
  - `lap_active` is constant 0 and the digits always show the live count.
  - The port list is identical either way.

## Test plan
- **Reset value and start latency:** assert `rst` mid-count at 12.34 → all outputs read 0 and the state is IDLE. Then apply a start_stop edge → `running` is 1 exactly 3 cycles after the input rises.
- **Counting and carries:** drive `clk_div` with a period of 20 clocks, start, apply 105 ticks, then stop → outputs read 01.05 and `running` is 0. A further 10 ticks leave the outputs at 01.05.
- **Rollover:** preload to 99.98 by running 9998 ticks, then apply 2 more ticks → outputs read 99.99, then 00.00. `wrap` is high for exactly 1 cycle and the next tick gives 00.01.
- **Clear priority:**
  - A clear edge in RUN at 00.50 → ignored and counting continues.
  - Simultaneous start_stop and clear edges in RUN → state STOP, digits held.
  - Simultaneous start_stop and clear edges in STOP → state IDLE, digits 00.00.
- **Tick/edge coincidence:** align a tick edge with a stop edge at 00.07 → outputs show 00.08. Align a tick edge with a restart edge → outputs stay at 00.08.
- **Lap (with `STOPWATCH_LAP_EN`):** apply a lap edge at 00.20, then 30 ticks → outputs still read 00.20 and `lap_active` is 1. A second lap edge → outputs read 00.50. A lap edge, then a stop edge → `lap_active` is 0 and the live total is shown. Without the macro, lap edges have no effect.
